imem_boot_controller: RTL and testbench
=======================================

# imem_boot_controller

Sequences the single-cycle core's instruction side through program load, run, halt and optional single-step. Owns the instruction memory's address/write port: a word-serial loader writes the program while the core is held, then the controller hands the port to the fetch PC and releases the fetch unit's halt. It sits between the fetch unit, the instruction memory and the loader/debug front end, and reports load and run statistics.

## Interface
- AW, 8: instruction memory word-address width; the memory holds 2^AW 32-bit words.
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ld_valid  in  1  loader word valid.
- ld_ready  out  1  controller accepts a loader word this cycle.
- ld_addr  in  AW  loader word address.
- ld_data  in  32  loader word data.
- ld_done  in  1  loader finished; sampled only in LOAD.
- load_req  in  1  request a reload; sampled only in HALTED.
- run_req  in  1  resume execution; sampled only in HALTED.
- step_req  in  1  execute one instruction; sampled only in HALTED, and only with SINGLE_STEP_EN.
- halt_insn  in  1  decoded halt instruction from the core.
- fetch_pc  in  32  byte PC from the fetch unit.
- mem_addr  out  AW  instruction memory word address.
- mem_we  out  1  instruction memory write enable.
- mem_wdata  out  32  instruction memory write data.
- core_halt  out  1  drives the fetch unit halt input; 1 freezes the PC.
- core_rst  out  1  one-cycle PC-clear pulse to the core.
- words_loaded  out  AW+1  count of words accepted in the current load, saturating at 2^AW.
- run_cycles  out  32  cycles spent in RUN or STEP since the last load, saturating at 0xFFFF_FFFF.
- state_o  out  3  current state encoding: LOAD=0, FLUSH=1, RUN=2, HALTED=3, STEP=4.

## Operation
- States: LOAD, FLUSH, RUN, HALTED, STEP. Reset state is LOAD.
- Values during reset:
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - words_loaded=0, run_cycles=0.
  - core_halt=1, core_rst=0, ld_ready=1.
- LOAD:
  - ld_ready=1, core_halt=1.
  - On ld_valid&&ld_ready, register we_q=1, wa_q=ld_addr, wd_q=ld_data; words_loaded++ (saturating). Otherwise we_q=0.
  - Memory port is driven from the registers: mem_we=we_q, mem_addr=wa_q, mem_wdata=wd_q.
  - Duplicate addresses are legal; the last write wins.
  - ld_done: go to FLUSH. If ld_valid is also high that cycle, the word is accepted first.
- FLUSH (exactly 1 cycle):
  - ld_ready=0, core_halt=1, core_rst=1.
  - The pending registered write completes this cycle. run_cycles is cleared.
  - Always goes to RUN.
- RUN:
  - core_halt=0, mem_we=0, mem_addr=fetch_pc[AW+1:2]. fetch_pc[1:0] and upper bits are ignored; addresses wrap modulo 2^AW.
  - run_cycles++ (saturating).
  - halt_insn: go to HALTED.
- HALTED:
  - core_halt=1, mem_addr=fetch_pc[AW+1:2], mem_we=0.
  - Priority: load_req > run_req > step_req.
  - load_req: go to LOAD and clear words_loaded.
  - run_req: go to RUN.
  - step_req: go to STEP.
- STEP:
  - core_halt=0 for exactly one cycle; run_cycles++.
  - Always returns to HALTED, whether or not halt_insn is asserted.
- Outside LOAD, ld_valid is ignored and ld_ready=0.

## Timing
- State register and we_q/wa_q/wd_q are flops.
- core_halt, core_rst, ld_ready, mem_addr and mem_we are decoded combinationally from state and the registers.
- Loader write latency: handshake in cycle N, memory write at edge N+1.
- ld_done in cycle N:
  - FLUSH in N+1.
  - RUN in N+2, with the first fetch at PC 0 (the core clears its PC on core_rst).
- halt_insn in cycle N: core_halt=1 from N+1. The instruction at the PC of cycle N is the last one executed.
- run_req in cycle N: core_halt=0 from N+1.
- Reset asserted mid-LOAD: any pending write is dropped (we_q cleared asynchronously) and the FSM restarts in LOAD.

## Configuration
- SINGLE_STEP_EN defined:
  - step_req is honoured in HALTED.
  - The STEP state exists.
- SINGLE_STEP_EN undefined:
  - step_req is ignored.
  - STEP is unreachable and is not synthesized.
  - Encoding 4 never appears on state_o.

## Test plan
- Reset, then load 3 words at addresses 0,1,2 (0x00000013, 0x00100093, 0x0000007F) with ld_done on the third handshake.
  - Required: three mem_we pulses one cycle after each handshake; words_loaded=3; FLUSH for one cycle with core_rst=1; RUN 2 cycles after ld_done.
- In RUN with fetch_pc=0x408 and AW=8: mem_addr=0x02. halt_insn in cycle N gives core_halt=1 at N+1, and run_cycles stops incrementing.
- In HALTED, assert load_req and run_req together: FSM goes to LOAD, words_loaded=0, ld_ready=1.
- Assert reset after 2 of 4 loader words, with a handshake in the reset cycle: no mem_we from that handshake; state=LOAD; words_loaded=0.
- With SINGLE_STEP_EN, step_req in HALTED: core_halt=0 for exactly 1 cycle, run_cycles +1, back to HALTED. Without SINGLE_STEP_EN: state stays HALTED.
- Stream 257 loader words with AW=8: words_loaded saturates at 256; word 257 overwrites address 0.

Source files
------------

// File: rtl/imem_boot_controller.sv
// imem_boot_controller: owns the instruction memory port and sequences the core
// through program load, flush, run, halt and (optionally) single-step.
// Optional feature macro: SINGLE_STEP_EN (enables the STEP state and step_req).
module imem_boot_controller #(
    parameter int unsigned AW = 8
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          ld_done,
    input  logic          load_req,
    input  logic          run_req,
    input  logic          step_req,
    input  logic          halt_insn,
    input  logic [31:0]   fetch_pc,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    output logic          core_halt,
    output logic          core_rst,
    output logic [AW:0]   words_loaded,
    output logic [31:0]   run_cycles,
    output logic [2:0]    state_o
);

    typedef enum logic [2:0] {
        ST_LOAD   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_RUN    = 3'd2,
        ST_HALTED = 3'd3
`ifdef SINGLE_STEP_EN
        ,
        ST_STEP   = 3'd4
`endif
    } state_t;

    localparam logic [AW:0] WL_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [31:0] RC_MAX = 32'hFFFF_FFFF;

    state_t        state;
    logic          we_q;
    logic [AW-1:0] wa_q;
    logic [31:0]   wd_q;
    logic          executing;
    logic          unused_bits;

    // State, loader write staging and statistics counters
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= ST_LOAD;
            we_q         <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
            words_loaded <= '0;
            run_cycles   <= '0;
        end else begin
            we_q <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (ld_valid) begin
                        we_q <= 1'b1;
                        wa_q <= ld_addr;
                        wd_q <= ld_data;
                        if (words_loaded != WL_MAX) begin
                            words_loaded <= words_loaded + (AW+1)'(1);
                        end
                    end
                    if (ld_done) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    run_cycles <= '0;
                    state      <= ST_RUN;
                end
                ST_RUN: begin
                    if (run_cycles != RC_MAX) begin
                        run_cycles <= run_cycles + 32'd1;
                    end
                    if (halt_insn) begin
                        state <= ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    if (load_req) begin
                        state        <= ST_LOAD;
                        words_loaded <= '0;
                    end else if (run_req) begin
                        state <= ST_RUN;
                    end
`ifdef SINGLE_STEP_EN
                    else if (step_req) begin
                        state <= ST_STEP;
                    end
`endif
                end
`ifdef SINGLE_STEP_EN
                ST_STEP: begin
                    if (run_cycles != RC_MAX) begin
                        run_cycles <= run_cycles + 32'd1;
                    end
                    state <= ST_HALTED;
                end
`endif
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

    // Core is released only while executing
`ifdef SINGLE_STEP_EN
    assign executing = (state == ST_RUN) || (state == ST_STEP);
`else
    assign executing = (state == ST_RUN);
`endif

    // Memory port belongs to the loader in LOAD/FLUSH, to the fetch PC otherwise
    assign mem_addr  = ((state == ST_LOAD) || (state == ST_FLUSH)) ? wa_q : fetch_pc[AW+1:2];
    assign mem_we    = we_q;
    assign mem_wdata = wd_q;
    assign ld_ready  = (state == ST_LOAD);
    assign core_rst  = (state == ST_FLUSH);
    assign core_halt = ~executing;
    assign state_o   = state;

    // Byte offset and PC bits above the memory range carry no information here
`ifdef SINGLE_STEP_EN
    assign unused_bits = ^{fetch_pc[31:AW+2], fetch_pc[1:0]};
`else
    assign unused_bits = ^{fetch_pc[31:AW+2], fetch_pc[1:0], step_req};
`endif

endmodule

// File: tb/tb_imem_boot_controller.sv
// Self-checking bench for imem_boot_controller (AW=8), scoreboarded memory writes.
module tb_imem_boot_controller;

    logic        CLOCK_50;
    logic        reset;
    logic        ld_valid;
    logic        ld_ready;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_done;
    logic        load_req;
    logic        run_req;
    logic        step_req;
    logic        halt_insn;
    logic [31:0] fetch_pc;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic        core_halt;
    logic        core_rst;
    logic [8:0]  words_loaded;
    logic [31:0] run_cycles;
    logic [2:0]  state_o;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned exp_rc;

    imem_boot_controller #(.AW(8)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_done     (ld_done),
        .load_req    (load_req),
        .run_req     (run_req),
        .step_req    (step_req),
        .halt_insn   (halt_insn),
        .fetch_pc    (fetch_pc),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .core_halt   (core_halt),
        .core_rst    (core_rst),
        .words_loaded(words_loaded),
        .run_cycles  (run_cycles),
        .state_o     (state_o)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step_clk();
        @(posedge CLOCK_50);
        #1;
    endtask

    // One loader handshake; the expected memory write goes to the scoreboard
    task automatic load_word(input logic [7:0] a, input logic [31:0] d, input logic done);
        wr_t e;
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_done  = done;
        e.addr   = a;
        e.data   = d;
        sb_q.push_back(e);
        step_clk();
        ld_valid = 1'b0;
        ld_done  = 1'b0;
    endtask

    // Every observed memory write must match the oldest expected one
    always @(negedge CLOCK_50) begin
        wr_t e;
        if (mem_we) begin
            check_eq("we_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("we_addr", 32'(mem_addr), 32'(e.addr));
                check_eq("we_data", mem_wdata, e.data);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        ld_done   = 1'b0;
        load_req  = 1'b0;
        run_req   = 1'b0;
        step_req  = 1'b0;
        halt_insn = 1'b0;
        fetch_pc  = '0;
        step_clk();
        step_clk();

        check_eq("rst_we",    32'(mem_we), 32'd0);
        check_eq("rst_addr",  32'(mem_addr), 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_wl",    32'(words_loaded), 32'd0);
        check_eq("rst_rc",    run_cycles, 32'd0);
        check_eq("rst_halt",  32'(core_halt), 32'd1);
        check_eq("rst_crst",  32'(core_rst), 32'd0);
        check_eq("rst_ready", 32'(ld_ready), 32'd1);
        check_eq("rst_state", 32'(state_o), 32'd0);
        reset = 1'b0;
        step_clk();

        // Load three words, ld_done with the last handshake
        load_word(8'd0, 32'h0000_0013, 1'b0);
        load_word(8'd1, 32'h0010_0093, 1'b0);
        load_word(8'd2, 32'h0000_007F, 1'b1);
        check_eq("flush_state", 32'(state_o), 32'd1);
        check_eq("flush_crst",  32'(core_rst), 32'd1);
        check_eq("flush_halt",  32'(core_halt), 32'd1);
        check_eq("flush_ready", 32'(ld_ready), 32'd0);
        check_eq("flush_wl",    32'(words_loaded), 32'd3);
        step_clk();
        check_eq("run_state", 32'(state_o), 32'd2);
        check_eq("run_crst",  32'(core_rst), 32'd0);
        check_eq("run_halt",  32'(core_halt), 32'd0);
        check_eq("run_rc0",   run_cycles, 32'd0);
        check_eq("run_pc0",   32'(mem_addr), 32'd0);
        fetch_pc = 32'h0000_0408;
        #1;
        check_eq("run_pc408", 32'(mem_addr), 32'h02);
        check_eq("run_we",    32'(mem_we), 32'd0);
        exp_rc = 0;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            exp_rc++;
        end
        check_eq("run_rc3", run_cycles, exp_rc);

        // Halt: core_halt rises one cycle after halt_insn, counter freezes
        halt_insn = 1'b1;
        #1;
        check_eq("halt_n_halt", 32'(core_halt), 32'd0);
        step_clk();
        exp_rc++;
        halt_insn = 1'b0;
        check_eq("halt_state", 32'(state_o), 32'd3);
        check_eq("halt_halt",  32'(core_halt), 32'd1);
        step_clk();
        step_clk();
        check_eq("halt_rc", run_cycles, exp_rc);
        check_eq("halt_addr", 32'(mem_addr), 32'h02);

        // Resume, then halt again
        run_req = 1'b1;
        step_clk();
        run_req = 1'b0;
        check_eq("resume_state", 32'(state_o), 32'd2);
        check_eq("resume_halt",  32'(core_halt), 32'd0);
        halt_insn = 1'b1;
        step_clk();
        exp_rc++;
        halt_insn = 1'b0;
        check_eq("rehalt_state", 32'(state_o), 32'd3);

        // Single step request
        step_req = 1'b1;
        step_clk();
        step_req = 1'b0;
`ifdef SINGLE_STEP_EN
        check_eq("step_state", 32'(state_o), 32'd4);
        check_eq("step_halt",  32'(core_halt), 32'd0);
        step_clk();
        exp_rc++;
        check_eq("step_back",  32'(state_o), 32'd3);
        check_eq("step_halt1", 32'(core_halt), 32'd1);
`else
        check_eq("nostep_state", 32'(state_o), 32'd3);
        check_eq("nostep_halt",  32'(core_halt), 32'd1);
        step_clk();
        check_eq("nostep_state2", 32'(state_o), 32'd3);
`endif
        check_eq("step_rc", run_cycles, exp_rc);

        // load_req outranks run_req
        load_req = 1'b1;
        run_req  = 1'b1;
        step_clk();
        load_req = 1'b0;
        run_req  = 1'b0;
        check_eq("reload_state", 32'(state_o), 32'd0);
        check_eq("reload_wl",    32'(words_loaded), 32'd0);
        check_eq("reload_ready", 32'(ld_ready), 32'd1);
        check_eq("reload_halt",  32'(core_halt), 32'd1);

        // Reset mid-load drops the pending write and the reset-cycle handshake
        load_word(8'h10, 32'hDEAD_0010, 1'b0);
        load_word(8'h11, 32'hDEAD_0011, 1'b0);
        check_eq("mid_wl2", 32'(words_loaded), 32'd2);
        check_eq("mid_we2", 32'(mem_we), 32'd1);
        reset    = 1'b1;
        ld_valid = 1'b1;
        ld_addr  = 8'h12;
        ld_data  = 32'hDEAD_0012;
        void'(sb_q.pop_back());
        #1;
        check_eq("mid_we_drop", 32'(mem_we), 32'd0);
        check_eq("mid_state",   32'(state_o), 32'd0);
        check_eq("mid_wl0",     32'(words_loaded), 32'd0);
        step_clk();
        reset    = 1'b0;
        ld_valid = 1'b0;
        step_clk();
        check_eq("post_we",    32'(mem_we), 32'd0);
        check_eq("post_wl",    32'(words_loaded), 32'd0);
        check_eq("post_state", 32'(state_o), 32'd0);

        // 257 words: count saturates at 256 and word 257 rewrites address 0
        for (int i = 0; i < 257; i++) begin
            load_word(8'(i), 32'hA000_0000 + 32'(i), 1'b0);
        end
        check_eq("sat_wl",   32'(words_loaded), 32'd256);
        check_eq("sat_addr", 32'(mem_addr), 32'd0);
        check_eq("sat_data", mem_wdata, 32'hA000_0100);
        step_clk();
        step_clk();
        check_eq("sat_wl_hold", 32'(words_loaded), 32'd256);
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
